// File: rtl/hazard_pkg.sv
// Shared opcode constants and FSM state type for the 3-stage core hazard controller.
package hazard_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  typedef enum logic [1:0] {
    RUN,
    LD_STALL,
    FLUSH,
    MDU_WAIT
  } hz_state_e;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/hazard_ctrl_unit_if.sv
// Decoder/pipeline-side signal bundle of the hazard controller.
interface hazard_ctrl_unit_if #(
  parameter int unsigned RA_W  = 5,
  parameter int unsigned CNT_W = 16
);
  logic [RA_W-1:0]  rs1_s2;
  logic [RA_W-1:0]  rs2_s2;
  logic [6:0]       opcode_s2;
  logic [RA_W-1:0]  rd_s3;
  logic             reg_wr_s3;
  logic             is_load_s3;
  logic             br_taken_s2;
  logic             mret_s2;
  logic             trap_req;
  logic             mdu_busy;
  logic             fwd_rs1;
  logic             fwd_rs2;
  logic             stall_s1;
  logic             stall_s2;
  logic             bubble_s3;
  logic             flush_s1;
  logic             flush_s2;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output rs1_s2, rs2_s2, opcode_s2, rd_s3, reg_wr_s3, is_load_s3,
    output br_taken_s2, mret_s2, trap_req, mdu_busy,
    input  fwd_rs1, fwd_rs2, stall_s1, stall_s2, bubble_s3, flush_s1, flush_s2, stall_cnt
  );

  modport slave (
    input  rs1_s2, rs2_s2, opcode_s2, rd_s3, reg_wr_s3, is_load_s3,
    input  br_taken_s2, mret_s2, trap_req, mdu_busy,
    output fwd_rs1, fwd_rs2, stall_s1, stall_s2, bubble_s3, flush_s1, flush_s2, stall_cnt
  );
endinterface

// File: rtl/hazard_fwd_dec.sv
// Operand-use decode and S3->S2 register match: forwarding selects and load-use detect.
module hazard_fwd_dec
  import hazard_pkg::*;
#(
  parameter int unsigned RA_W = 5
) (
  input  logic [RA_W-1:0] i_rs1_s2,
  input  logic [RA_W-1:0] i_rs2_s2,
  input  logic [6:0]      i_opcode_s2,
  input  logic [RA_W-1:0] i_rd_s3,
  input  logic            i_reg_wr_s3,
  input  logic            i_is_load_s3,
  output logic            o_fwd_rs1,
  output logic            o_fwd_rs2,
  output logic            o_ld_haz
);

  logic w_use1;
  logic w_use2;
  logic w_wr_ok;
  logic w_hit1;
  logic w_hit2;

  always_comb begin
    w_use1 = 1'b0;
    w_use2 = 1'b0;
    case (i_opcode_s2)
      OP_R, OP_STORE, OP_BRANCH: begin
        w_use1 = 1'b1;
        w_use2 = 1'b1;
      end
      OP_I, OP_LOAD, OP_JALR: w_use1 = 1'b1;
      OP_LUI, OP_AUIPC, OP_JAL, OP_SYSTEM: ;
      default: ;
    endcase
  end

  // x0 is never a real producer, so writes to it must not match.
  assign w_wr_ok   = i_reg_wr_s3 & (i_rd_s3 != '0);
  assign w_hit1    = w_use1 & w_wr_ok & (i_rs1_s2 == i_rd_s3);
  assign w_hit2    = w_use2 & w_wr_ok & (i_rs2_s2 == i_rd_s3);
  assign o_fwd_rs1 = w_hit1 & ~i_is_load_s3;
  assign o_fwd_rs2 = w_hit2 & ~i_is_load_s3;
  assign o_ld_haz  = (w_hit1 | w_hit2) & i_is_load_s3;

endmodule

// File: rtl/hazard_ctrl_unit.sv
// Hazard controller: stall/flush sequencing FSM, saturating stall counter, forwarding decode.
module hazard_ctrl_unit
  import hazard_pkg::*;
#(
  parameter int unsigned RA_W         = 5,
  parameter int unsigned LD_STALL_CYC = 1,
  parameter int unsigned FLUSH_CYC    = 1,
  parameter int unsigned CNT_W        = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  hazard_ctrl_unit_if.slave  io_bus
);

  localparam int unsigned  CW        = max_u(LD_STALL_CYC, FLUSH_CYC);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [CW-1:0] LD_RELOAD = CW'(LD_STALL_CYC - 1);
  localparam logic [CW-1:0] FL_RELOAD = CW'(FLUSH_CYC - 1);

  hz_state_e        r_state;
  hz_state_e        w_state_nxt;
  logic [CW-1:0]    r_cnt;
  logic [CW-1:0]    w_cnt_nxt;
  logic [CNT_W-1:0] r_stall_cnt;
  logic             w_ld_haz;
  logic             w_redirect;
  logic             w_stall;
  logic             w_flush1;
  logic             w_flush2;

  hazard_fwd_dec #(
    .RA_W(RA_W)
  ) u_fwd_dec (
    .i_rs1_s2    (io_bus.rs1_s2),
    .i_rs2_s2    (io_bus.rs2_s2),
    .i_opcode_s2 (io_bus.opcode_s2),
    .i_rd_s3     (io_bus.rd_s3),
    .i_reg_wr_s3 (io_bus.reg_wr_s3),
    .i_is_load_s3(io_bus.is_load_s3),
    .o_fwd_rs1   (io_bus.fwd_rs1),
    .o_fwd_rs2   (io_bus.fwd_rs2),
    .o_ld_haz    (w_ld_haz)
  );

  assign w_redirect = io_bus.br_taken_s2 | io_bus.mret_s2;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_stall     = 1'b0;
    w_flush1    = 1'b0;
    w_flush2    = 1'b0;
    if (io_bus.trap_req) begin
      // A trap overrides every state, including an ongoing flush (which restarts).
      w_flush1    = 1'b1;
      w_flush2    = 1'b1;
      w_cnt_nxt   = FL_RELOAD;
      w_state_nxt = (FLUSH_CYC > 1) ? FLUSH : RUN;
    end else begin
      unique case (r_state)
        RUN: begin
          if (w_redirect) begin
            w_flush1    = 1'b1;
            w_cnt_nxt   = FL_RELOAD;
            w_state_nxt = (FLUSH_CYC > 1) ? FLUSH : RUN;
          end else if (w_ld_haz) begin
            w_stall     = 1'b1;
            w_cnt_nxt   = LD_RELOAD;
            w_state_nxt = (LD_STALL_CYC > 1) ? LD_STALL : RUN;
          end else if (io_bus.mdu_busy) begin
            w_stall     = 1'b1;
            w_state_nxt = MDU_WAIT;
          end
        end
        LD_STALL: begin
          // Redirects are ignored here: S2 operands are stale until the stall ends.
          w_stall   = 1'b1;
          w_cnt_nxt = r_cnt - CNT_ONE;
          if (r_cnt == CNT_ONE) w_state_nxt = RUN;
        end
        FLUSH: begin
          w_flush1  = 1'b1;
          w_cnt_nxt = r_cnt - CNT_ONE;
          if (r_cnt == CNT_ONE) w_state_nxt = RUN;
        end
        MDU_WAIT: begin
          if (io_bus.mdu_busy) w_stall = 1'b1;
          else                 w_state_nxt = RUN;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= RUN;
      r_cnt       <= '0;
      r_stall_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_stall && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end
  end

  // Enables are forced low for the whole reset assertion, not just from the next edge.
  assign io_bus.stall_s1  = w_stall & rst_n;
  assign io_bus.stall_s2  = w_stall & rst_n;
  assign io_bus.bubble_s3 = w_stall & rst_n;
  assign io_bus.flush_s1  = w_flush1 & rst_n;
  assign io_bus.flush_s2  = w_flush2 & rst_n;
  assign io_bus.stall_cnt = r_stall_cnt;

endmodule
